cond_flag_unit: RTL
===================

Name: cond_flag_unit

Overview:
Registered condition-flag unit for the processor datapath and the successor to the flat flag multiplexer. It holds the ALU status flags in a flag register and keeps a shadow copy for interrupt save/restore. It evaluates a selected branch condition, with optional inversion and same-cycle forwarding, and returns a registered taken/valid pair one cycle after each evaluation request.

Parameters:
N_FLAGS, 6, number of status flags stored; legal range 2..(2**SEL_W - 2)
SEL_W, 3, width of condition select field
FWD_EN, 1, 1 = evaluation sees flags written in the same cycle; 0 = evaluation sees the registered flags only

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
flags_in  input  N_FLAGS  new flag values from the ALU
flags_we  input  1  load flags_in into the flag register
save  input  1  copy the flag register into the shadow register
restore  input  1  copy the shadow register into the flag register
eval  input  1  request a condition evaluation this cycle
select  input  SEL_W  condition index
invert  input  1  invert the selected condition
cond_taken  output  1  registered evaluation result
cond_valid  output  1  high for exactly one cycle, one cycle after eval
flags_out  output  N_FLAGS  current flag register contents
shadow_out  output  N_FLAGS  current shadow register contents

Behaviour:
- Reset (asynchronous, active-high): flag register = 0, shadow register = 0, cond_taken = 0, cond_valid = 0. Takes effect immediately and is held while rst = 1. Any evaluation in flight is discarded, so no cond_valid is produced after reset deasserts for a pre-reset eval.
- Flag register next value, in priority order: restore -> shadow; else flags_we -> flags_in; else hold.
- Shadow register: save -> flag register's current (pre-edge) value; else hold.
- save and restore in the same cycle swap the two registers: shadow gets the old flags and flags get the old shadow.
- Effective flags for evaluation (eff):
  - FWD_EN = 1: the next value of the flag register (restore forwarding takes priority over flags_in forwarding).
  - FWD_EN = 0: the registered flags.
- Raw condition from select:
  - select < N_FLAGS: eff[select].
  - select == 2**SEL_W - 1: constant 1 ("always").
  - any other value: constant 0 ("never").
- Result = raw XOR invert, so invert together with the "always" select gives "never".
- Latency is 1 cycle. On an edge with eval = 1: cond_valid <= 1, cond_taken <= result. On an edge with eval = 0: cond_valid <= 0 and cond_taken holds its last value.
- Back-to-back eval is accepted every cycle with no stall and no backpressure. cond_valid stays high continuously and cond_taken tracks each result.
- flags_out and shadow_out are direct register outputs with no combinational path from the inputs.
- Inputs are sampled only at the rising edge; select and invert are don't-care when eval = 0.

Test Plan:
1. Reset mid-operation: load flags 6'b010010, assert eval with select = 1, then assert rst half a cycle before the edge -> cond_valid, cond_taken, flags_out and shadow_out are all 0 immediately; no cond_valid pulse follows reset release.
2. Select sweep: flags register = 6'b010010; run eval with select 0..7 on consecutive cycles, invert = 0 -> cond_taken sequence 0,1,0,0,1,0,0,1 (select 6 = never, select 7 = always) with cond_valid continuously high; repeat with invert = 1 -> 1,0,1,1,0,1,1,0.
3. Forwarding: flags register = 0; in the same cycle assert flags_we with flags_in = 6'b000100, eval, select = 2 -> FWD_EN = 1 gives cond_taken = 1 next cycle; FWD_EN = 0 gives cond_taken = 0, and a following eval gives 1.
4. Save/restore:
   - flags = 6'b101010; pulse save; load 6'b000001.
   - Pulse restore -> flags_out = 6'b101010, shadow_out unchanged.
   - Assert restore and flags_we (flags_in = 6'b111111) together -> restore wins, flags_out = shadow.
5. Swap: flags = 6'b000011, shadow = 6'b110000; assert save and restore together -> flags_out = 6'b110000, shadow_out = 6'b000011.
6. Parameter sweep: N_FLAGS = 4, SEL_W = 3 -> select 4..6 give "never", select 7 gives "always"; flags_out is 4 bits wide.

Source files
------------

// File: rtl/cond_flag_unit.sv
// cond_flag_unit
//   Registered condition-flag unit. Holds the ALU status flags plus a shadow
//   copy for interrupt save/restore. It evaluates a selected branch condition
//   with optional inversion and same-cycle forwarding. A registered
//   taken/valid pair is returned one cycle after each evaluation request.
//
// Parameters
//   N_FLAGS : number of stored status flags (2 .. 2**SEL_W-2)
//   SEL_W   : width of the condition select field
//   FWD_EN  : 1 = evaluation sees flags written in the same cycle,
//             0 = evaluation sees the registered flags only
//
// Ports
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   flags_in    : new flag values from the ALU
//   flags_we    : load flags_in into the flag register
//   save        : copy flag register into shadow register
//   restore     : copy shadow register into flag register (beats flags_we)
//   eval        : request a condition evaluation this cycle
//   select      : condition index (< N_FLAGS flag, all-ones always, else never)
//   invert      : invert the selected condition
//   cond_taken  : registered evaluation result
//   cond_valid  : one-cycle pulse, one cycle after each eval
//   flags_out   : flag register contents
//   shadow_out  : shadow register contents
module cond_flag_unit #(
  parameter int N_FLAGS = 6,
  parameter int SEL_W   = 3,
  parameter int FWD_EN  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_FLAGS-1:0] flags_in,
  input  logic               flags_we,
  input  logic               save,
  input  logic               restore,
  input  logic               eval,
  input  logic [SEL_W-1:0]   select,
  input  logic               invert,
  output logic               cond_taken,
  output logic               cond_valid,
  output logic [N_FLAGS-1:0] flags_out,
  output logic [N_FLAGS-1:0] shadow_out
);

  logic [N_FLAGS-1:0] flags_q;
  logic [N_FLAGS-1:0] shadow_q;
  logic [N_FLAGS-1:0] flags_next;
  logic [N_FLAGS-1:0] eff;
  logic               raw;
  logic               result;
  logic               taken_q;
  logic               valid_q;

  // Restore has priority over a normal ALU write.
  always_comb begin
    if (restore) begin
      flags_next = shadow_q;
    end else if (flags_we) begin
      flags_next = flags_in;
    end else begin
      flags_next = flags_q;
    end
  end

  always_comb begin
    if (FWD_EN != 0) begin
      eff = flags_next;
    end else begin
      eff = flags_q;
    end
  end

  // Compare-based selection keeps out-of-range select values from indexing
  // past the flag vector; those fall through to "never" unless all-ones.
  always_comb begin
    raw = 1'b0;
    for (int unsigned i = 0; i < N_FLAGS; i++) begin
      if (select == SEL_W'(i)) begin
        raw = eff[i];
      end
    end
    if (select == '1) begin
      raw = 1'b1;
    end
  end

  assign result = raw ^ invert;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q  <= '0;
      shadow_q <= '0;
      taken_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      flags_q <= flags_next;
      if (save) begin
        shadow_q <= flags_q;
      end
      valid_q <= eval;
      if (eval) begin
        taken_q <= result;
      end
    end
  end

  assign cond_taken = taken_q;
  assign cond_valid = valid_q;
  assign flags_out  = flags_q;
  assign shadow_out = shadow_q;

endmodule
